// File: rtl/ahb_decoder_pipe.sv
// AHB address decoder: combinational address-phase selects, registered data-phase selects,
// and an error-responding default slave. Define AHB_DEC_HREMAP_EN to enable the slave 0 / REMAP_SLV window swap.
module ahb_decoder_pipe #(
  parameter int AHB_ADDR_WIDTH = 32,
  parameter int SLAVE_NUM      = 3,
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_LOW_ADDR =
    {32'h0000_2404, 32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVE_NUM*AHB_ADDR_WIDTH-1:0] SLV_HIGH_ADDR =
    {32'h0000_24FF, 32'h0000_100F, 32'h0000_03FF},
  parameter int REMAP_SLV      = 1
) (
  input  logic                      hclk,
  input  logic                      hreset,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]                htrans,
  input  logic                      hready,
  input  logic                      hremap,
  output logic [SLAVE_NUM-1:0]      hsel,
  output logic                      default_slv_sel,
  output logic [SLAVE_NUM-1:0]      dp_sel,
  output logic                      dp_default,
  output logic                      hreadyout_def,
  output logic                      hresp_def,
  output logic [7:0]                dec_err_cnt
);

  localparam int AW = AHB_ADDR_WIDTH;
  localparam int REMAP_IDX = (REMAP_SLV >= 0 && REMAP_SLV < SLAVE_NUM) ? REMAP_SLV : 0;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_t;

  if (SLAVE_NUM < 1 || SLAVE_NUM > 16) begin : g_bad_slave_num
    $error("ahb_decoder_pipe: SLAVE_NUM must be within 1..16");
  end

  logic                 w_remap_active;
  logic                 w_trans_active;
  logic [SLAVE_NUM-1:0] w_match;
  logic [SLAVE_NUM-1:0] w_pri_sel;
  logic                 w_err_start;
  def_state_t           w_state_nxt;

  def_state_t           r_state;
  logic [SLAVE_NUM-1:0] r_dp_sel;
  logic                 r_dp_default;
  logic [1:0]           r_dp_htrans;
  logic [7:0]           r_err_cnt;

`ifdef AHB_DEC_HREMAP_EN
  assign w_remap_active = hremap;
`else
  logic w_unused_hremap;
  assign w_remap_active  = 1'b0;
  assign w_unused_hremap = hremap;
`endif

  // Under remap, slave 0 and REMAP_IDX borrow each other's window; all others keep their own.
  for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_win
    localparam int SWAP_IDX = (gi == 0) ? REMAP_IDX : ((gi == REMAP_IDX) ? 0 : gi);
    localparam logic [AW-1:0] NORM_LO = SLV_LOW_ADDR[gi*AW +: AW];
    localparam logic [AW-1:0] NORM_HI = SLV_HIGH_ADDR[gi*AW +: AW];
    localparam logic [AW-1:0] SWAP_LO = SLV_LOW_ADDR[SWAP_IDX*AW +: AW];
    localparam logic [AW-1:0] SWAP_HI = SLV_HIGH_ADDR[SWAP_IDX*AW +: AW];

    logic [AW-1:0] w_lo;
    logic [AW-1:0] w_hi;

    assign w_lo         = w_remap_active ? SWAP_LO : NORM_LO;
    assign w_hi         = w_remap_active ? SWAP_HI : NORM_HI;
    assign w_match[gi]  = (haddr >= w_lo) && (haddr <= w_hi);
  end

  // x & -x isolates the lowest set bit: lowest-index slave wins on overlap.
  assign w_pri_sel       = w_match & (~w_match + SLAVE_NUM'(1));
  assign w_trans_active  = (htrans != HTRANS_IDLE);
  assign hsel            = w_trans_active ? w_pri_sel : '0;
  assign default_slv_sel = w_trans_active && (w_match == '0);

  // BUSY to an unmapped address is excluded here, so it completes with a zero-wait OKAY.
  assign w_err_start = hready && default_slv_sel &&
                       ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values, independent of the order the always_ff blocks are evaluated in.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_dp_sel     <= '0;
      r_dp_default <= 1'b0;
      r_dp_htrans  <= HTRANS_IDLE;
    end else if (hready) begin
      r_dp_sel     <= hsel;
      r_dp_default <= default_slv_sel;
      r_dp_htrans  <= htrans;
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state <= ST_OKAY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every signal written here gets a default before the case, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt   = r_state;
    hreadyout_def = 1'b1;
    hresp_def     = 1'b0;
    unique case (r_state)
      ST_OKAY: begin
        w_state_nxt = w_err_start ? ST_ERR1 : ST_OKAY;
      end
      ST_ERR1: begin
        hreadyout_def = 1'b0;
        hresp_def     = 1'b1;
        w_state_nxt   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp_def   = 1'b1;
        w_state_nxt = w_err_start ? ST_ERR1 : ST_OKAY;
      end
      default: begin
        w_state_nxt = ST_OKAY;
      end
    endcase
  end

  // ERR1 is never re-entered from itself, so each cycle heading into ERR1 is one new error.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_err_cnt <= 8'h00;
    end else if ((w_state_nxt == ST_ERR1) && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign dp_sel      = r_dp_sel;
  assign dp_default  = r_dp_default;
  assign dec_err_cnt = r_err_cnt;

  // An error response always belongs to a NONSEQ/SEQ transfer captured on the same edge.
  a_err1_has_transfer: assert property (
    @(posedge hclk) disable iff (hreset)
    (r_state == ST_ERR1) |-> r_dp_htrans[1]
  );

endmodule

// File: tb/tb_ahb_decoder_pipe.sv
// Scoreboard bench for ahb_decoder_pipe with default parameters; honours AHB_DEC_HREMAP_EN when defined.
module tb_ahb_decoder_pipe;

  localparam logic [1:0] T_IDLE = 2'b00;
  localparam logic [1:0] T_BUSY = 2'b01;
  localparam logic [1:0] T_NSEQ = 2'b10;
  localparam logic [1:0] T_SEQ  = 2'b11;

  logic        hclk = 1'b0;
  logic        hreset;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hready;
  logic        hremap;
  logic [2:0]  hsel;
  logic        default_slv_sel;
  logic [2:0]  dp_sel;
  logic        dp_default;
  logic        hreadyout_def;
  logic        hresp_def;
  logic [7:0]  dec_err_cnt;

  always #5 hclk = ~hclk;

  ahb_decoder_pipe dut (
    .hclk            (hclk),
    .hreset          (hreset),
    .haddr           (haddr),
    .htrans          (htrans),
    .hready          (hready),
    .hremap          (hremap),
    .hsel            (hsel),
    .default_slv_sel (default_slv_sel),
    .dp_sel          (dp_sel),
    .dp_default      (dp_default),
    .hreadyout_def   (hreadyout_def),
    .hresp_def       (hresp_def),
    .dec_err_cnt     (dec_err_cnt)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       def;
    logic       rdy;
    logic       resp;
    logic [7:0] cnt;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  string      cur_tag  = "init";

  logic       m_remap  = 1'b0;
  logic [2:0] m_dp_sel = 3'b000;
  logic       m_dp_def = 1'b0;
  int         m_state  = 0;     // 0 OKAY, 1 ERR1, 2 ERR2
  logic [7:0] m_cnt    = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference decode from the documented default windows.
  function automatic logic [2:0] model_hsel(input logic [31:0] a, input logic [1:0] t);
    logic [31:0] lo0, hi0, lo1, hi1, tmp;
    lo0 = 32'h0000_0000; hi0 = 32'h0000_03FF;
    lo1 = 32'h0000_1000; hi1 = 32'h0000_100F;
`ifdef AHB_DEC_HREMAP_EN
    if (m_remap) begin
      tmp = lo0; lo0 = lo1; lo1 = tmp;
      tmp = hi0; hi0 = hi1; hi1 = tmp;
    end
`endif
    if (t == T_IDLE) return 3'b000;
    if (a >= lo0 && a <= hi0) return 3'b001;
    if (a >= lo1 && a <= hi1) return 3'b010;
    if (a >= 32'h0000_2404 && a <= 32'h0000_24FF) return 3'b100;
    return 3'b000;
  endfunction

  function automatic logic model_def(input logic [31:0] a, input logic [1:0] t);
    return (t != T_IDLE) && (model_hsel(a, t) == 3'b000);
  endfunction

  // One bus cycle: drive, check address phase, push expectation, clock, pop and compare.
  task automatic step(input logic [31:0] a, input logic [1:0] t, input logic rdy, input logic rst);
    exp_t e;
    logic err;
    haddr  = a;
    htrans = t;
    hready = rdy;
    hreset = rst;
    hremap = m_remap;
    #1;
    check({cur_tag, ":hsel"}, 32'(hsel), 32'(model_hsel(a, t)));
    check({cur_tag, ":def_sel"}, 32'(default_slv_sel), 32'(model_def(a, t)));
    err = rdy && model_def(a, t) && t[1];
    if (rst) begin
      m_dp_sel = 3'b000;
      m_dp_def = 1'b0;
      m_state  = 0;
      m_cnt    = 8'h00;
    end else begin
      if (rdy) begin
        m_dp_sel = model_hsel(a, t);
        m_dp_def = model_def(a, t);
      end
      if (m_state == 1) begin
        m_state = 2;
      end else if (err) begin
        m_state = 1;
        if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      end else begin
        m_state = 0;
      end
    end
    e.sel  = m_dp_sel;
    e.def  = m_dp_def;
    e.rdy  = (m_state != 1);
    e.resp = (m_state != 0);
    e.cnt  = m_cnt;
    sb.push_back(e);
    @(posedge hclk);
    #1;
    e = sb.pop_front();
    check({cur_tag, ":dp_sel"}, 32'(dp_sel), 32'(e.sel));
    check({cur_tag, ":dp_default"}, 32'(dp_default), 32'(e.def));
    check({cur_tag, ":hreadyout_def"}, 32'(hreadyout_def), 32'(e.rdy));
    check({cur_tag, ":hresp_def"}, 32'(hresp_def), 32'(e.resp));
    check({cur_tag, ":dec_err_cnt"}, 32'(dec_err_cnt), 32'(e.cnt));
  endtask

  logic [31:0] addr_pool [13];
  int          issued;
  logic        rdy_bus;

  initial begin
    addr_pool = '{32'h0000_0000, 32'h0000_03FF, 32'h0000_0400, 32'h0000_0FFF,
                  32'h0000_1000, 32'h0000_100F, 32'h0000_1010, 32'h0000_2403,
                  32'h0000_2404, 32'h0000_24FF, 32'h0000_2500, 32'hFFFF_FFFF,
                  32'h8000_1000};
    hreset = 1'b1; haddr = '0; htrans = T_IDLE; hready = 1'b1; hremap = 1'b0;

    cur_tag = "reset";
    step(32'h0000_0000, T_NSEQ, 1'b1, 1'b1);
    step(32'h0000_3000, T_NSEQ, 1'b1, 1'b1);
    check("reset:dp_sel_zero", 32'(dp_sel), 32'h0);
    check("reset:okay_ready", 32'(hreadyout_def), 32'h1);

    cur_tag = "map_basic";
    step(32'h0000_03FF, T_NSEQ, 1'b1, 1'b0);
    check("map_basic:dp_sel_001", 32'(dp_sel), 32'h1);
    haddr = 32'h0000_0400; htrans = T_NSEQ; #1;
    check("map_basic:unmapped_def", 32'(default_slv_sel), 32'h1);
    step(32'h0000_0400, T_NSEQ, 1'b1, 1'b0);
    step(32'h0000_0000, T_IDLE, 1'b1, 1'b0);
    step(32'h0000_0000, T_IDLE, 1'b1, 1'b0);

    cur_tag = "err_seq";
    step(32'h0000_0000, T_IDLE, 1'b1, 1'b1);
    step(32'h0000_3000, T_NSEQ, 1'b1, 1'b0);
    check("err_seq:err1", {30'h0, hreadyout_def, hresp_def}, 32'h1);
    step(32'h0000_0000, T_IDLE, 1'b0, 1'b0);
    check("err_seq:err2", {30'h0, hreadyout_def, hresp_def}, 32'h3);
    step(32'h0000_0000, T_IDLE, 1'b1, 1'b0);
    check("err_seq:okay", {30'h0, hreadyout_def, hresp_def}, 32'h2);
    check("err_seq:cnt_one", 32'(dec_err_cnt), 32'h1);

    cur_tag = "wait_hold";
    step(32'h0000_03FF, T_NSEQ, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(32'h0000_100F, T_NSEQ, 1'b0, 1'b0);
    check("wait_hold:held", 32'(dp_sel), 32'h1);
    step(32'h0000_100F, T_NSEQ, 1'b1, 1'b0);
    check("wait_hold:dp_sel_010", 32'(dp_sel), 32'h2);

    cur_tag = "busy_unmapped";
    step(32'h0000_3000, T_BUSY, 1'b1, 1'b0);
    check("busy_unmapped:okay", {30'h0, hreadyout_def, hresp_def}, 32'h2);
    check("busy_unmapped:dp_default", 32'(dp_default), 32'h1);

    cur_tag = "bounds";
    for (int i = 0; i < 13; i++) begin
      step(addr_pool[i], T_NSEQ, 1'b1, 1'b0);
      step(addr_pool[i], T_SEQ, 1'b0, 1'b0);
      step(addr_pool[i], T_IDLE, 1'b1, 1'b0);
    end

    cur_tag = "remap";
    m_remap = 1'b1;
    step(32'h0000_1000, T_NSEQ, 1'b1, 1'b0);
    step(32'h0000_0000, T_NSEQ, 1'b1, 1'b0);
    step(32'h0000_100F, T_SEQ, 1'b1, 1'b0);
    step(32'h0000_03FF, T_NSEQ, 1'b1, 1'b0);
    step(32'h0000_2404, T_NSEQ, 1'b1, 1'b0);
    m_remap = 1'b0;
    step(32'h0000_1000, T_NSEQ, 1'b1, 1'b0);
    step(32'h0000_0000, T_NSEQ, 1'b1, 1'b0);

    cur_tag = "random";
    for (int i = 0; i < 200; i++) begin
      m_remap = 1'($urandom_range(0, 1));
      step((i % 4 == 3) ? 32'($urandom) : addr_pool[$urandom_range(0, 12)],
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), (i == 120));
    end
    m_remap = 1'b0;

    cur_tag = "saturate";
    step(32'h0000_0000, T_IDLE, 1'b1, 1'b1);
    issued = 0;
    while (issued < 260) begin
      rdy_bus = (m_state != 1);
      step(32'h0000_3000, T_NSEQ, rdy_bus, 1'b0);
      if (rdy_bus) issued++;
    end
    check("saturate:cnt_ff", 32'(dec_err_cnt), 32'hFF);
    check("saturate:in_err1", {30'h0, hreadyout_def, hresp_def}, 32'h1);
    step(32'h0000_3000, T_NSEQ, 1'b0, 1'b1);
    check("saturate:reset_okay", {30'h0, hreadyout_def, hresp_def}, 32'h2);
    check("saturate:reset_cnt", 32'(dec_err_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_decoder_pipe.md
AHB_DECODER_PIPE -- requirements
Module: ahb_decoder_pipe

Interface
REQ-001 SHALL provide parameter AHB_ADDR_WIDTH, default 32: address width.
REQ-002 SHALL provide parameter SLAVE_NUM, default 3: number of decoded slaves, range 1..16.
REQ-003 SHALL provide parameter SLV_LOW_ADDR, default {32'h0000_2404, 32'h0000_1000, 32'h0000_0000}: packed per-slave inclusive low bound, index 0 in LSBs.
REQ-004 SHALL provide parameter SLV_HIGH_ADDR, default {32'h0000_24FF, 32'h0000_100F, 32'h0000_03FF}: packed per-slave inclusive high bound.
REQ-005 SHALL provide parameter REMAP_SLV, default 1: slave whose window swaps with slave 0 under remap.
REQ-006 Clock and reset: one clock; reset is synchronous and active-high.
REQ-007 hclk  in  1  bus clock, all state on rising edge.
REQ-008 hreset  in  1  synchronous active-high reset.
REQ-009 haddr  in  AHB_ADDR_WIDTH  address-phase address.
REQ-010 htrans  in  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-011 hready  in  1  bus-level HREADY; 1 ends the current data phase.
REQ-012 hremap  in  1  remap request, level-sensitive.
REQ-013 hsel  out  SLAVE_NUM  address-phase one-hot slave select, combinational.
REQ-014 default_slv_sel  out  1  address-phase select of default slave, combinational.
REQ-015 dp_sel  out  SLAVE_NUM  registered data-phase one-hot select, for response muxing.
REQ-016 dp_default  out  1  registered data-phase default-slave select.
REQ-017 hreadyout_def  out  1  default-slave HREADYOUT.
REQ-018 hresp_def  out  1  default-slave HRESP (1 = ERROR).
REQ-019 dec_err_cnt  out  8  saturating count of erroring transfers.

Function
REQ-020 Slave i SHALL match when SLV_LOW_ADDR[i] <= haddr <= SLV_HIGH_ADDR[i], full address width, both bounds inclusive.
REQ-021 On overlapping windows, only the lowest-index match SHALL appear in hsel (strict one-hot).
REQ-022 hsel SHALL equal the priority-resolved match when htrans != IDLE, else all zero.
REQ-023 default_slv_sel SHALL be 1 iff htrans != IDLE and no slave matches.
REQ-024 On each rising edge with hready=1, dp_sel <= hsel, dp_default <= default_slv_sel, and the sampled htrans SHALL be stored; with hready=0 these SHALL hold.
REQ-025 Default-slave FSM states: OKAY, ERR1, ERR2.
REQ-026 OKAY: hreadyout_def=1, hresp_def=0; on edge with hready=1, default_slv_sel=1 and htrans in {NONSEQ, SEQ} -> ERR1; otherwise stay.
REQ-027 ERR1: hreadyout_def=0, hresp_def=1; unconditionally -> ERR2 next cycle.
REQ-028 ERR2: hreadyout_def=1, hresp_def=1; on next edge, re-evaluate exactly as OKAY (back-to-back error allowed, ERR2->ERR1).
REQ-029 BUSY to an unmapped address SHALL get a zero-wait OKAY response (no ERR1 entry).
REQ-030 dec_err_cnt SHALL increment by 1 on each ERR1 entry and saturate at 8'hFF.

Reset
REQ-031 While hreset=1 at a rising edge: dp_sel=0, dp_default=0, FSM=OKAY, stored htrans=IDLE, dec_err_cnt=0.
REQ-032 Reset asserted mid-error (ERR1 or ERR2) SHALL return FSM to OKAY next edge with hreadyout_def=1, hresp_def=0.
REQ-033 hsel and default_slv_sel SHALL remain combinational and unaffected by reset.

Configuration
REQ-034 Macro AHB_DEC_HREMAP_EN: when defined and hremap=1, windows of slave 0 and slave REMAP_SLV SHALL be swapped for matching; hremap=0 gives the normal map.
REQ-035 Without AHB_DEC_HREMAP_EN, hremap SHALL be ignored (port retained) and the normal map always used.

Verification
REQ-036 haddr=0x0000_03FF, htrans=NONSEQ, hready=1 -> hsel=001; next cycle dp_sel=001; haddr=0x0000_0400 -> default_slv_sel=1.
REQ-037 haddr=0x0000_3000 NONSEQ, hready=1 -> ERR1 (hreadyout_def=0, hresp_def=1), then ERR2 (1,1), then OKAY; dec_err_cnt=1.
REQ-038 haddr=0x0000_100F NONSEQ with hready=0 held 3 cycles -> dp_sel unchanged; on hready=1 edge dp_sel=010.
REQ-039 AHB_DEC_HREMAP_EN defined, hremap=1, haddr=0x0000_1000 NONSEQ -> hsel=001; haddr=0x0000_0000 -> hsel=010; hremap=0 -> original map.
REQ-040 260 back-to-back unmapped NONSEQ transfers -> dec_err_cnt=0xFF; hreset=1 asserted in ERR1 -> next cycle OKAY, dec_err_cnt=0.
REQ-041 haddr=0x0000_3000 htrans=BUSY, hready=1 -> default_slv_sel=1, FSM stays OKAY, hreadyout_def=1, hresp_def=0.
